// File: rtl/mau_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and data width.
package mau_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/mau_lane_fmt.sv
// Combinational lane logic: extracts/extends a loaded lane and merges a store lane
// into the old RAM word.
module mau_lane_fmt
    import mau_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] new_data,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = new_data;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged    = word;
                merged[{offset, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged    = word;
                merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_data = word;
                merged    = new_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-only RAM; sub-word stores use read-modify-write.
// Define MAU_MISALIGN_TRAP_EN to report misaligned/illegal requests instead of aligning down.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import mau_pkg::*;

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_bad;
    logic [1:0]        eff_size;
    logic [1:0]        eff_off;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign req_ready = (state == IDLE);
    assign ram_we    = (state == WR);

`ifdef MAU_MISALIGN_TRAP_EN
    always_comb begin
        req_bad  = (req_size == 2'b11) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                   ((req_size == SZ_HALF) && req_addr[0]);
        eff_size = req_size;
        eff_off  = req_addr[1:0];
    end
`else
    // Without trapping, illegal size acts as word and offsets are aligned down.
    always_comb begin
        req_bad  = 1'b0;
        eff_size = (req_size == 2'b11) ? SZ_WORD : req_size;
        case (eff_size)
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_BYTE: eff_off = req_addr[1:0];
            default: eff_off = 2'b00;
        endcase
    end
`endif

    mau_lane_fmt u_lane_fmt (
        .word        (ram_rdata),
        .new_data    (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_WORD;
            off_q      <= 2'b00;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= eff_size;
                        off_q    <= eff_off;
                        uns_q    <= req_unsigned;
                        wdata_q  <= req_wdata;
                        ram_addr <= req_addr[ADDR_W-1:2];
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && (eff_size == SZ_WORD)) begin
                            ram_wdata <= req_wdata;
                            state     <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                // A store here captures the merged old word; a load completes.
                RD: begin
                    if (we_q) begin
                        ram_wdata <= merged;
                        state     <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cycle;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   we_pulses = 0;

    mem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    assign ram_rdata = mem[ram_addr];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle = cycle + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each resp_valid and checks the pulse drops.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_we) we_pulses = we_pulses + 1;
            if (prev_valid) begin
                checkOutput("resp_valid_drop", {31'b0, resp_valid}, 32'h0);
                checkOutput("resp_rdata_clear", resp_rdata, 32'h0);
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("resp_rdata", resp_rdata, e.rdata);
                    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    checkOutput("resp_latency", 32'(cycle - e.acc_cycle), 32'(e.lat));
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input logic expect_resp);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'h0, 32'h1);
        end else begin
            e.rdata     = exp_rdata;
            e.err       = exp_err;
            e.lat       = exp_lat;
            e.acc_cycle = cycle;
            if (expect_resp) sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drainResponses();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sb_q.size() != 0) checkOutput("drain_timeout", 32'(sb_q.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h80FF7F01;
        mem[1] <= 32'h11223344;
        mem[3] <= 32'h55667788;
        mem[4] <= 32'hA5A5A5A5;
        #22;
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("reset_ram_we", {31'b0, ram_we}, 32'h0);
        checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
        checkOutput("reset_ram_addr", {26'b0, ram_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back loads keep req_valid high across busy cycles.
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h01, 32'h0, 32'h0000007F, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h03, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b1, 8'h03, 32'h0, 32'h00000080, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 32'h00000001, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h02, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b1, 8'h02, 32'h0, 32'h000080FF, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 8'h00, 32'h0, 32'h00007F01, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 8'h00, 32'h0, 32'h80FF7F01, 1'b0, 2, 1'b1);
        drainResponses();

        applyStimulus(1'b1, 2'b10, 1'b0, 8'h06, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1);
        drainResponses();
        checkOutput("store_byte_mem1", mem[1], 32'h11AA3344);
        checkOutput("store_byte_we_pulses", 32'(we_pulses), 32'd1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 8'h0E, 32'h1234CAFE, 32'h0, 1'b0, 3, 1'b1);
        drainResponses();
        checkOutput("store_word_mem2", mem[2], 32'hDEADBEEF);
        checkOutput("store_half_mem3", mem[3], 32'hCAFE7788);
        checkOutput("store_we_pulses", 32'(we_pulses), 32'd3);

`ifdef MAU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h05, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 8'h09, 32'h0000BBBB, 32'h0, 1'b1, 1, 1'b1);
        drainResponses();
        checkOutput("misalign_store_mem2", mem[2], 32'hDEADBEEF);
        checkOutput("misalign_we_pulses", 32'(we_pulses), 32'd3);
`else
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h05, 32'h0, 32'h11AA3344, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 32'h80FF7F01, 1'b0, 2, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 8'h09, 32'h0000BBBB, 32'h0, 1'b0, 3, 1'b1);
        drainResponses();
        checkOutput("misalign_store_mem2", mem[2], 32'hDEADBBBB);
        checkOutput("misalign_we_pulses", 32'(we_pulses), 32'd4);
`endif

        // Abort a byte store in WR with reset; the old word must survive.
        applyStimulus(1'b1, 2'b10, 1'b0, 8'h10, 32'h0000003C, 32'h0, 1'b0, 3, 1'b0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_in_wr_ram_we", {31'b0, ram_we}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ram_we_drop", {31'b0, ram_we}, 32'h0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_mem4", mem[4], 32'hA5A5A5A5);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1'b1);
        drainResponses();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
